// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM/IO port between icache line refills and
// LSB loads/stores. Each request becomes a sequence of single-byte transfers.
// The read data is assembled and returned with a one-cycle done pulse.
module mem_ctrl #(
  parameter int unsigned LINE_BYTES = 16,
  parameter logic [31:0] IO_BASE    = 32'h30000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic                    IC_req,
  input  logic [31:0]             IC_addr,
  output logic                    IC_done,
  output logic [8*LINE_BYTES-1:0] IC_line,
  input  logic                    LSB_req,
  input  logic                    LSB_wr,
  input  logic [1:0]              LSB_len,
  input  logic [31:0]             LSB_addr,
  input  logic [31:0]             LSB_wdata,
  output logic                    LSB_done,
  output logic [31:0]             LSB_rdata,
  input  logic                    ROB_jp_wrong
);

  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int CNT_W  = $clog2(LINE_BYTES) + 1;
  localparam int IDX_W  = $clog2(LINE_W);

  typedef enum logic [1:0] {IDLE, IC_RD, LS_RD, LS_WR} state_e;

  // Convert the LSB size code to a byte count. Code 11 is treated as a word.
  function automatic logic [CNT_W-1:0] len_bytes(input logic [1:0] len);
    case (len)
      2'b00:   return CNT_W'(1);
      2'b01:   return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;        // byte being transferred
  logic [CNT_W-1:0]    n_q, n_d;            // bytes in this transfer
  logic [31:0]         base_q, base_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [LINE_W-1:0]   buf_q, buf_d;        // read assembly buffer
  logic [31:0]         mem_a_q, mem_a_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                mem_wr_q, mem_wr_d;
  logic                ic_done_q, ic_done_d;
  logic                lsb_done_q, lsb_done_d;
  logic [LINE_W-1:0]   ic_line_q, ic_line_d;
  logic [31:0]         lsb_rdata_q, lsb_rdata_d;
  logic                frozen_q;            // previous cycle had rdy low

  logic [31:0]         cnt_ext;
  logic [31:0]         wr_addr;
  logic [IDX_W-1:0]    rd_bit;
  logic [4:0]          wr_bit;

  assign cnt_ext = 32'(cnt_q);
  assign wr_addr = base_q + cnt_ext;
  assign rd_bit  = IDX_W'({cnt_q, 3'b000});
  assign wr_bit  = {cnt_q[1:0], 3'b000};

  // Next-state logic: arbitration, byte sequencing, IO stall, flush and replay.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;
    ic_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    ic_line_d   = ic_line_q;
    lsb_rdata_d = lsb_rdata_q;

    case (state_q)
      IDLE: begin
        // A requester still holds its request during its own done cycle.
        // That request must not be accepted again.
        if (!ic_done_q && !lsb_done_q) begin
          if (LSB_req) begin
            base_d = LSB_addr;
            n_d    = len_bytes(LSB_len);
            cnt_d  = '0;
            buf_d  = '0;
            if (LSB_wr) begin
              wdata_d = LSB_wdata;
              state_d = LS_WR;
            end else begin
              mem_a_d = LSB_addr;
              state_d = LS_RD;
            end
          end else if (IC_req && !ROB_jp_wrong) begin
            base_d  = IC_addr;
            n_d     = CNT_W'(LINE_BYTES);
            cnt_d   = '0;
            buf_d   = '0;
            mem_a_d = IC_addr;
            state_d = IC_RD;
          end
        end
      end

      IC_RD, LS_RD: begin
        if (state_q == IC_RD && ROB_jp_wrong) begin
          state_d = IDLE;
        end else if (!frozen_q) begin
          // The first cycle after a freeze keeps mem_a unchanged.
          // The pending byte is therefore re-read instead of sampled.
          buf_d[rd_bit +: 8] = mem_din;
          if (cnt_q == n_q - CNT_W'(1)) begin
            state_d = IDLE;
            if (state_q == IC_RD) begin
              ic_done_d = 1'b1;
              ic_line_d = buf_d;
            end else begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = buf_d[31:0];
            end
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            mem_a_d = base_q + cnt_ext + 32'd1;
          end
        end
      end

      LS_WR: begin
        if (cnt_q == n_q) begin
          state_d    = IDLE;
          lsb_done_d = 1'b1;
        end else if (!(wr_addr >= IO_BASE && io_buffer_full)) begin
          mem_wr_d   = 1'b1;
          mem_a_d    = wr_addr;
          mem_dout_d = wdata_q[wr_bit +: 8];
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, frozen while rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the assembly buffer is plain flops, not a RAM macro. Resetting it
    // with the rest of the state costs nothing and keeps it X-free.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      ic_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      ic_line_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy) begin
      // NOTE: non-blocking assignments make every register take its value
      // from the same pre-edge state, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      ic_done_q   <= ic_done_d;
      lsb_done_q  <= lsb_done_d;
      ic_line_q   <= ic_line_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  // Remember a freeze so that the first ready cycle after it replays the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frozen_q <= 1'b0;
    else     frozen_q <= ~rdy;
  end

  // A pending write is suppressed while frozen. It is issued once rdy returns.
  assign mem_wr    = mem_wr_q & rdy;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign IC_done   = ic_done_q;
  assign IC_line   = ic_line_q;
  assign LSB_done  = lsb_done_q;
  assign LSB_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus around a RAM model. One compare process checks
// completions and writes against a transaction-level model. Directed tests pin
// latencies and literal values.
module tb_mem_ctrl;

  localparam int          LB      = 16;
  localparam logic [31:0] IO_BASE = 32'h30000;

  logic          clk = 1'b0;
  logic          rst, rdy;
  logic [7:0]    mem_din, mem_dout;
  logic [31:0]   mem_a;
  logic          mem_wr, io_buffer_full;
  logic          IC_req, IC_done;
  logic [31:0]   IC_addr;
  logic [8*LB-1:0] IC_line;
  logic          LSB_req, LSB_wr, LSB_done, ROB_jp_wrong;
  logic [1:0]    LSB_len;
  logic [31:0]   LSB_addr, LSB_wdata, LSB_rdata;

  int checks = 0;
  int errors = 0;

  mem_ctrl #(.LINE_BYTES(LB), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .IC_req(IC_req), .IC_addr(IC_addr), .IC_done(IC_done), .IC_line(IC_line),
    .LSB_req(LSB_req), .LSB_wr(LSB_wr), .LSB_len(LSB_len), .LSB_addr(LSB_addr),
    .LSB_wdata(LSB_wdata), .LSB_done(LSB_done), .LSB_rdata(LSB_rdata),
    .ROB_jp_wrong(ROB_jp_wrong)
  );

  always #5 clk = ~clk;

  // RAM model: 1 KiB aliased over the address space. A byte at the address
  // registered at one edge is sampled at the next edge. IO writes do not land in RAM.
  logic [7:0] ram [0:1023];
  assign mem_din = ram[mem_a[9:0]];
  always @(posedge clk) if (mem_wr && mem_a < IO_BASE) ram[mem_a[9:0]] <= mem_dout;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [8*LB-1:0] exp_line(input logic [31:0] a);
    logic [8*LB-1:0] r = '0;
    logic [31:0] ak;
    for (int k = 0; k < LB; k++) begin
      ak = a + 32'(k);
      r[8*k +: 8] = ram[ak[9:0]];
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] len);
    logic [31:0] r = '0;
    logic [31:0] ak;
    for (int k = 0; k < nbytes(len); k++) begin
      ak = a + 32'(k);
      r[8*k +: 8] = ram[ak[9:0]];
    end
    return r;
  endfunction

  // Compare process: completions and writes checked against the model.
  logic io_full_edge = 1'b0;
  always @(posedge clk) io_full_edge <= io_buffer_full;

  int   wr_idx = 0;
  logic ic_prev = 1'b0, lsb_prev = 1'b0;
  logic [31:0] wd;
  always @(negedge clk) begin
    if (rst) begin
      wr_idx = 0; ic_prev = 1'b0; lsb_prev = 1'b0;
    end else begin
      if (!rdy) check("mem_wr_frozen", mem_wr, 0);
      if (IC_done || LSB_done) check("done_exclusive", IC_done && LSB_done, 0);
      if (IC_done) begin
        check("ic_req_held", IC_req, 1);
        check("ic_line_model", IC_line, exp_line(IC_addr));
        check("ic_done_pulse", ic_prev, 0);
      end
      if (LSB_done) begin
        check("lsb_done_pulse", lsb_prev, 0);
        if (LSB_wr) begin
          check("st_byte_count", wr_idx, nbytes(LSB_len));
          wr_idx = 0;
        end else begin
          check("lsb_rdata_model", LSB_rdata, exp_load(LSB_addr, LSB_len));
        end
      end
      if (mem_wr) begin
        wd = LSB_wdata >> (8 * wr_idx);
        check("st_active", LSB_req && LSB_wr, 1);
        check("st_addr", mem_a, LSB_addr + 32'(wr_idx));
        check("st_data", mem_dout, wd[7:0]);
        if (mem_a >= IO_BASE) check("io_write_while_full", io_full_edge, 0);
        wr_idx++;
      end
      ic_prev  = IC_done;
      lsb_prev = LSB_done;
    end
  end

  // Per-iteration hooks, applied just after the given posedge of a run.
  int frz_on = -1, frz_off = -1, io_off = -1, rob_on = -1, rob_off = -1;
  logic [31:0] a_trace [0:63];
  logic        wr_trace [0:63];

  task automatic clear_hooks();
    frz_on = -1; frz_off = -1; io_off = -1; rob_on = -1; rob_off = -1;
  endtask

  // Iteration i samples after the i-th edge following the stimulus.
  // When a request was just driven, iteration 1 follows the accept edge.
  task automatic run(input bit want_ic, input int max_it, output int m, output bit got);
    got = 1'b0;
    m   = 0;
    for (int it = 1; it <= max_it; it++) begin
      @(posedge clk);
      #1;
      if (it == frz_on)  rdy = 1'b0;
      if (it == frz_off) rdy = 1'b1;
      if (it == io_off)  io_buffer_full = 1'b0;
      if (it == rob_on)  ROB_jp_wrong = 1'b1;
      if (it == rob_off) ROB_jp_wrong = 1'b0;
      @(negedge clk);
      if (it < 64) begin
        a_trace[it]  = mem_a;
        wr_trace[it] = mem_wr;
      end
      if (want_ic ? IC_done : LSB_done) begin
        m   = it;
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input string name, input bit want_ic, input int exp_m);
    int m;
    bit got;
    run(want_ic, 60, m, got);
    check({name, "_latency"}, m, exp_m);
  endtask

  task automatic lsb_go(input logic wr, input logic [1:0] len, input logic [31:0] a,
                        input logic [31:0] d);
    @(posedge clk);
    #1;
    LSB_req = 1'b1; LSB_wr = wr; LSB_len = len; LSB_addr = a; LSB_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  m;
    bit  got;
    logic [127:0] saved_line;

    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; ROB_jp_wrong = 1'b0;
    IC_req = 1'b0; IC_addr = '0;
    LSB_req = 1'b0; LSB_wr = 1'b0; LSB_len = '0; LSB_addr = '0; LSB_wdata = '0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i * 7) ^ 8'h5A;
    for (int k = 0; k < 16; k++) ram[256 + k] = 8'(k);
    ram[32] = 8'h11; ram[33] = 8'h22; ram[34] = 8'h33; ram[35] = 8'h44;
    for (int i = 0; i < 64; i++) begin a_trace[i] = '0; wr_trace[i] = 1'b0; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_ic_done", IC_done, 0);
    check("rst_lsb_done", LSB_done, 0);
    rst = 1'b0;

    // Line refill at 0x100, RAM[0x100+k] = k.
    @(posedge clk); #1; IC_req = 1'b1; IC_addr = 32'h100;
    wait_done("ic100", 1, 17);
    check("ic100_line", IC_line, 128'h0F0E0D0C0B0A09080706050403020100);
    check("ic100_first_addr", a_trace[1], 32'h100);
    check("ic100_last_addr", a_trace[16], 32'h10F);
    #1; IC_req = 1'b0;

    // Simultaneous requests: the LSB wins, and the refill starts after LSB_done.
    lsb_go(1'b0, 2'b10, 32'h20, 32'h0);
    IC_req = 1'b1; IC_addr = 32'h300;
    wait_done("lsb_first", 0, 5);
    check("lsb_first_rdata", LSB_rdata, 32'h44332211);
    check("lsb_first_addr", a_trace[1], 32'h20);
    check("lsb_first_no_ic", IC_done, 0);
    #1; LSB_req = 1'b0;
    wait_done("ic_after_lsb", 1, 18);
    #1; IC_req = 1'b0;

    // Mispredict during byte 6 of a refill: no IC_done and IC_line kept, then a new refill.
    saved_line = IC_line;
    @(posedge clk); #1; IC_req = 1'b1; IC_addr = 32'h100;
    rob_on = 7; rob_off = 8;
    run(1'b1, 8, m, got);
    clear_hooks();
    check("flush_no_done", got, 0);
    check("flush_line_kept", IC_line, saved_line);
    #1; IC_addr = 32'h200;
    wait_done("ic_refetch", 1, 17);
    #1; IC_req = 1'b0;

    // Two-byte IO store with the IO buffer full for the first 3 cycles.
    lsb_go(1'b1, 2'b01, 32'h30000, 32'h0000BEEF);
    io_buffer_full = 1'b1; io_off = 3;
    wait_done("io_store", 0, 6);
    clear_hooks();
    check("io_stall_wr", wr_trace[3], 0);
    check("io_wr0_addr", a_trace[4], 32'h30000);
    check("io_wr0_en", wr_trace[4], 1);
    check("io_wr1_addr", a_trace[5], 32'h30001);
    check("io_wr1_en", wr_trace[5], 1);
    #1; LSB_req = 1'b0;

    // Word store with one frozen cycle that lands on a pending write, then read back.
    lsb_go(1'b1, 2'b10, 32'h50, 32'hDEADBEEF);
    frz_on = 3; frz_off = 4;
    wait_done("st_freeze", 0, 7);
    clear_hooks();
    #1; LSB_req = 1'b0;
    lsb_go(1'b0, 2'b10, 32'h50, 32'h0);
    wait_done("ld_back", 0, 5);
    check("ld_back_rdata", LSB_rdata, 32'hDEADBEEF);
    #1; LSB_req = 1'b0;

    // Word load with rdy low for 2 cycles: the done pulse is 3 cycles late.
    lsb_go(1'b0, 2'b10, 32'h40, 32'h0);
    frz_on = 2; frz_off = 4;
    wait_done("ld_freeze", 0, 8);
    clear_hooks();
    check("ld_freeze_rdata", LSB_rdata, 32'h8F949D9A);
    #1; LSB_req = 1'b0;

    // One-byte load, which returns zero-extended data.
    lsb_go(1'b0, 2'b00, 32'h23, 32'h0);
    wait_done("ld_byte", 0, 2);
    check("ld_byte_rdata", LSB_rdata, 32'h44);
    #1; LSB_req = 1'b0;

    // Size code 11 at the top of the address space: the address wraps to 0.
    lsb_go(1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0);
    wait_done("ld_wrap", 0, 5);
    check("ld_wrap_addr", a_trace[3], 32'h0);
    check("ld_wrap_rdata", LSB_rdata, 32'h5D5AA3A8);
    #1; LSB_req = 1'b0;

    // Reset in the middle of a refill.
    @(posedge clk); #1; IC_req = 1'b1; IC_addr = 32'h100;
    run(1'b1, 6, m, got);
    #2; rst = 1'b1; IC_req = 1'b0;
    #1;
    check("arst_mem_a", mem_a, 0);
    check("arst_mem_dout", mem_dout, 0);
    check("arst_mem_wr", mem_wr, 0);
    check("arst_ic_done", IC_done, 0);
    check("arst_lsb_done", LSB_done, 0);
    check("arst_ic_line", IC_line, 0);
    check("arst_lsb_rdata", LSB_rdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_mem_a", mem_a, 0);
      check("idle_done", IC_done | LSB_done, 0);
    end
    lsb_go(1'b0, 2'b01, 32'h20, 32'h0);
    wait_done("post_rst_load", 0, 3);
    check("post_rst_rdata", LSB_rdata, 32'h2211);
    #1; LSB_req = 1'b0;

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
